// File: rtl/spi_reg_slave_if.sv
// Register-bank side of spi_reg_slave: address, write strobe/data, read strobe/data.
// The SPI block is the master of this bus; the register bank is the slave.
interface spi_reg_slave_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_en;

  modport master (output addr, wr_data, wr_en, rd_en, input rd_data);
  modport slave  (input addr, wr_data, wr_en, rd_en, output rd_data);
endinterface

// File: rtl/spi_reg_slave.sv
// Oversampled SPI slave bridging an SPI master to a register bank (selectable CPOL/CPHA).
// Define SPI_REG_BURST_EN for auto-increment bursts; otherwise one data word per frame.
module spi_reg_slave #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic mosi,
  input  logic cs_n,
  output logic miso,
  output logic miso_oe,
  output logic busy,
  output logic frame_err,
  spi_reg_slave_if.master reg_bus
);

`ifdef SPI_REG_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  localparam int MAX_BITS = (ADDR_W + 1 > DATA_W) ? ADDR_W + 1 : DATA_W;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  logic [SYNC_STAGES-1:0] sclk_sync_reg, mosi_sync_reg, cs_sync_reg;
  logic                   sclk_prev_reg;

  logic [2:0]        state_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [ADDR_W-1:0] cmd_reg;
  logic [DATA_W-2:0] rx_reg;
  logic [DATA_W-1:0] tx_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic              wr_en_reg, rd_en_reg, rd_en_d_reg;
  logic              miso_reg, miso_oe_reg, busy_reg, frame_err_reg;
  logic              armed_reg;

  logic sclk_s, mosi_s, cs_s;
  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic word_done;
  logic [ADDR_W:0]   cmd_next;
  logic [DATA_W-1:0] rx_next;

  // Pure synchronisers: no reset, so a reset never fakes a pin edge.
  always_ff @(posedge clk) begin
    sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk};
    mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
    cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], cs_n};
    sclk_prev_reg <= sclk_sync_reg[SYNC_STAGES-1];
  end

  assign sclk_s      = sclk_sync_reg[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_reg[SYNC_STAGES-1];
  assign cs_s        = cs_sync_reg[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev_reg;
  assign sclk_fall   = ~sclk_s & sclk_prev_reg;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cmd_next    = {cmd_reg, mosi_s};
  assign rx_next     = {rx_reg, mosi_s};

  always_comb begin
    word_done = 1'b0;
    if (sample_edge) begin
      case (state_reg)
        ST_CMD:       word_done = (bit_cnt_reg == CMD_LAST);
        ST_WR, ST_RD: word_done = (bit_cnt_reg == DATA_LAST);
        default:      word_done = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= '0;
      cmd_reg       <= '0;
      rx_reg        <= '0;
      tx_reg        <= '0;
      addr_reg      <= '0;
      wr_data_reg   <= '0;
      wr_en_reg     <= 1'b0;
      rd_en_reg     <= 1'b0;
      rd_en_d_reg   <= 1'b0;
      miso_reg      <= 1'b0;
      miso_oe_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      frame_err_reg <= 1'b0;
      armed_reg     <= 1'b0;
    end else begin
      wr_en_reg     <= 1'b0;
      rd_en_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      rd_en_d_reg   <= rd_en_reg;
      busy_reg      <= ~cs_s;
      // A frame may only start after cs_n has been seen high since reset.
      if (cs_s) armed_reg <= 1'b1;
      if (BURST && wr_en_reg) addr_reg <= addr_reg + 1'b1;
      if (rd_en_d_reg) tx_reg <= reg_bus.rd_data;

      case (state_reg)
        ST_IDLE: begin
          if (!cs_s && armed_reg) begin
            state_reg   <= ST_CMD;
            bit_cnt_reg <= '0;
          end
        end
        ST_CMD: begin
          if (sample_edge) begin
            cmd_reg     <= cmd_next[ADDR_W-1:0];
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (word_done) begin
              addr_reg    <= cmd_next[ADDR_W-1:0];
              bit_cnt_reg <= '0;
              rd_en_reg   <= cmd_next[ADDR_W];
              state_reg   <= cmd_next[ADDR_W] ? ST_RD : ST_WR;
            end
          end
        end
        ST_WR: begin
          if (sample_edge) begin
            rx_reg      <= rx_next[DATA_W-2:0];
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (word_done) begin
              wr_data_reg <= rx_next;
              wr_en_reg   <= 1'b1;
              bit_cnt_reg <= '0;
              state_reg   <= BURST ? ST_WR : ST_HOLD;
            end
          end
        end
        ST_RD: begin
          if (shift_edge) begin
            miso_reg    <= tx_reg[DATA_W-1];
            miso_oe_reg <= 1'b1;
            tx_reg      <= tx_reg << 1;
          end
          if (sample_edge) begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (word_done) begin
              bit_cnt_reg <= '0;
              if (BURST) begin
                addr_reg  <= addr_reg + 1'b1;
                rd_en_reg <= 1'b1;
              end else begin
                state_reg   <= ST_HOLD;
                miso_reg    <= 1'b0;
                miso_oe_reg <= 1'b0;
              end
            end
          end
        end
        default: ; // ST_HOLD: ignore sclk until cs_n rises
      endcase

      // cs_n high ends any frame; a word completing this very cycle still commits.
      if (state_reg != ST_IDLE && cs_s) begin
        state_reg     <= ST_IDLE;
        bit_cnt_reg   <= '0;
        rd_en_reg     <= 1'b0;
        miso_reg      <= 1'b0;
        miso_oe_reg   <= 1'b0;
        frame_err_reg <= (bit_cnt_reg != '0) && !word_done;
      end
    end
  end

  assign miso             = miso_reg;
  assign miso_oe          = miso_oe_reg;
  assign busy             = busy_reg;
  assign frame_err        = frame_err_reg;
  assign reg_bus.addr     = addr_reg;
  assign reg_bus.wr_data  = wr_data_reg;
  assign reg_bus.wr_en    = wr_en_reg;
  assign reg_bus.rd_en    = rd_en_reg;

endmodule
